// File: rtl/prng_word_packer_if.sv
// Sample-in / word-out bus of the LFSR word packer.
// master = packer side, slave = LFSR + consumer side.
interface prng_word_packer_if #(
    parameter int CODE_W  = 4,
    parameter int NIBBLES = 4,
    parameter int DEPTH   = 4
);
    localparam int WORD_W = CODE_W * NIBBLES;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic [CODE_W-1:0] code_in;
    logic              code_valid;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;
    logic [CNT_W-1:0]  fifo_count;
    logic              overflow;
    logic              stuck;

    modport master (
        input  code_in, code_valid, word_ready,
        output word_out, word_valid, fifo_count, overflow, stuck
    );

    modport slave (
        output code_in, code_valid, word_ready,
        input  word_out, word_valid, fifo_count, overflow, stuck
    );
endinterface

// File: rtl/prng_word_packer.sv
// Packs NIBBLES LFSR codes into one word and queues it in a fall-through FIFO.
// Optional stuck-generator detection is enabled by defining PRNG_STUCK_DETECT_EN.
module prng_word_packer #(
    parameter int CODE_W      = 4,
    parameter int NIBBLES     = 4,
    parameter int DEPTH       = 4,
    parameter int STUCK_LIMIT = 8
) (
    input logic               clk,
    input logic               preset_n,
    prng_word_packer_if.master bus
);
    localparam int WORD_W = CODE_W * NIBBLES;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    logic              pack_en;
    logic              push;
    logic [WORD_W-1:0] push_word;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] sr;
    logic              last;

    // ---------------------------------------------------------------- stuck
`ifdef PRNG_STUCK_DETECT_EN
    localparam int RUN_W = $clog2(STUCK_LIMIT + 1);

    logic [CODE_W-1:0] prev;
    logic [RUN_W-1:0]  run;
    logic              stuck_r;
    logic              same;
    logic [RUN_W-1:0]  run_nxt;
    logic              stuck_nxt;

    // run==0 only after reset, so the very first sample always starts a new run
    always_comb begin
        same      = (run != '0) && (bus.code_in == prev);
        run_nxt   = RUN_W'(1);
        stuck_nxt = 1'b0;
        if (same) begin
            run_nxt   = (run == RUN_W'(STUCK_LIMIT)) ? run : run + RUN_W'(1);
            stuck_nxt = stuck_r | (run_nxt == RUN_W'(STUCK_LIMIT));
        end
    end

    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            prev    <= '0;
            run     <= '0;
            stuck_r <= 1'b0;
        end else if (bus.code_valid) begin
            prev    <= bus.code_in;
            run     <= run_nxt;
            stuck_r <= stuck_nxt;
        end
    end

    // the sample that completes a stuck run is already withheld from packing
    assign pack_en   = bus.code_valid & ~stuck_nxt;
    assign bus.stuck = stuck_r;
`else
    assign pack_en   = bus.code_valid;
    assign bus.stuck = 1'b0;
`endif

    // --------------------------------------------------------------- packer
    assign last      = (idx == IDX_W'(NIBBLES - 1));
    assign push      = pack_en & last;
    assign push_word = {sr[WORD_W-CODE_W-1:0], bus.code_in};

    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            idx <= '0;
            sr  <= '0;
        end else if (pack_en) begin
            sr  <= push_word;
            idx <= last ? '0 : idx + IDX_W'(1);
        end
    end

    // ----------------------------------------------------------------- fifo
    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              ovf;
    logic              full;
    logic              pop;
    logic              wr_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign pop   = (count != '0) & bus.word_ready;
    // a full FIFO still accepts when the head leaves on the same edge
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_en & ~pop)
                count <= count + CNT_W'(1);
            else if (~wr_en & pop)
                count <= count - CNT_W'(1);
            if (push & full & ~pop)
                ovf <= 1'b1;
        end
    end

    assign bus.word_out   = mem[rd_ptr];
    assign bus.word_valid = (count != '0);
    assign bus.fifo_count = count;
    assign bus.overflow   = ovf;
endmodule

// File: tb/tb_prng_word_packer.sv
// Directed bench for prng_word_packer; popped words are scored against an expected-word queue.
module tb_prng_word_packer;
    logic clk = 1'b0;
    logic preset_n = 1'b0;
    always #5 clk = ~clk;

    prng_word_packer_if #(.CODE_W(4), .NIBBLES(4), .DEPTH(4)) bus ();

    prng_word_packer #(.CODE_W(4), .NIBBLES(4), .DEPTH(4), .STUCK_LIMIT(8)) dut (
        .clk     (clk),
        .preset_n(preset_n),
        .bus     (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] expq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [3:0] c);
        bus.code_valid = 1'b1;
        bus.code_in    = c;
        tick();
        bus.code_valid = 1'b0;
    endtask

    task automatic word4(input logic [15:0] w);
        for (int i = 0; i < 4; i++) sample(w[15-4*i -: 4]);
    endtask

    // a handshake seen before the edge means the head word leaves on that edge
    always @(negedge clk) begin
        if (preset_n && bus.word_valid && bus.word_ready) begin
            check("word_expected", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) check("word_out", bus.word_out, expq.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.code_in    = '0;
        bus.code_valid = 1'b0;
        bus.word_ready = 1'b0;

        // reset state
        #12;
        check("rst_word_out", bus.word_out, 0);
        check("rst_word_valid", bus.word_valid, 0);
        check("rst_fifo_count", bus.fifo_count, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_stuck", bus.stuck, 0);
        @(posedge clk);
        #1 preset_n = 1'b1;

        // single word, fall-through latency, immediate pop
        bus.word_ready = 1'b1;
        expq.push_back(16'h1234);
        word4(16'h1234);
        check("t1_valid", bus.word_valid, 1);
        check("t1_word", bus.word_out, 16'h1234);
        check("t1_count1", bus.fifo_count, 1);
        tick();
        check("t1_count0", bus.fifo_count, 0);
        check("t1_valid0", bus.word_valid, 0);

        // fill, then overflow drops the fifth word
        bus.word_ready = 1'b0;
        expq.push_back(16'h0123);
        expq.push_back(16'h4567);
        expq.push_back(16'h89AB);
        expq.push_back(16'hCDEF);
        for (int i = 0; i < 16; i++) sample(4'(i));
        check("t2_count_full", bus.fifo_count, 4);
        check("t2_ovf_not_yet", bus.overflow, 0);
        for (int i = 0; i < 4; i++) sample(4'(i));
        check("t2_count_still", bus.fifo_count, 4);
        check("t2_ovf", bus.overflow, 1);
        bus.word_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("t2_drained", bus.fifo_count, 0);
        check("t2_ovf_sticky", bus.overflow, 1);
        check("t2_queue_empty", expq.size(), 0);

        // reset mid-cycle discards a partial word and clears overflow
        sample(4'h7);
        sample(4'h8);
        preset_n = 1'b0;
        #2;
        check("t4_rst_valid", bus.word_valid, 0);
        check("t4_rst_count", bus.fifo_count, 0);
        check("t4_rst_ovf", bus.overflow, 0);
        check("t4_rst_word", bus.word_out, 0);
        #1 preset_n = 1'b1;
        expq.push_back(16'hABCD);
        word4(16'hABCD);
        check("t4_word", bus.word_out, 16'hABCD);
        tick();
        check("t4_count0", bus.fifo_count, 0);

        // push and pop on the same edge while full
        bus.word_ready = 1'b0;
        expq.push_back(16'h1357);
        expq.push_back(16'h2468);
        expq.push_back(16'h9ABC);
        expq.push_back(16'hDEF0);
        word4(16'h1357);
        word4(16'h2468);
        word4(16'h9ABC);
        word4(16'hDEF0);
        check("t3_full", bus.fifo_count, 4);
        expq.push_back(16'h5A5A);
        sample(4'h5);
        sample(4'hA);
        sample(4'h5);
        bus.word_ready = 1'b1;
        sample(4'hA);
        check("t3_count", bus.fifo_count, 4);
        check("t3_ovf", bus.overflow, 0);
        check("t3_head", bus.word_out, 16'h2468);
        for (int i = 0; i < 4; i++) tick();
        check("t3_drained", bus.fifo_count, 0);
        check("t3_queue_empty", expq.size(), 0);

        // run of zeros then a differing code
`ifdef PRNG_STUCK_DETECT_EN
        expq.push_back(16'h0000);
        expq.push_back(16'h0005);
        for (int i = 0; i < 7; i++) sample(4'h0);
        check("t5_stuck_before", bus.stuck, 0);
        sample(4'h0);
        check("t5_stuck_set", bus.stuck, 1);
        sample(4'h0);
        sample(4'h0);
        check("t5_stuck_held", bus.stuck, 1);
        check("t5_no_word", bus.word_valid, 0);
        sample(4'h5);
        check("t5_stuck_clr", bus.stuck, 0);
        check("t5_word", bus.word_out, 16'h0005);
`else
        expq.push_back(16'h0000);
        expq.push_back(16'h0000);
        expq.push_back(16'h5678);
        for (int i = 0; i < 8; i++) sample(4'h0);
        check("t6_stuck_zero", bus.stuck, 0);
        sample(4'h5);
        check("t6_stuck_zero2", bus.stuck, 0);
        sample(4'h6);
        sample(4'h7);
        sample(4'h8);
        check("t6_word", bus.word_out, 16'h5678);
`endif
        for (int i = 0; i < 3; i++) tick();
        check("final_count", bus.fifo_count, 0);
        check("final_queue_empty", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
